mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and load/store, serialising multi-byte accesses.
// Define MEM_PORT_ARB_RR_EN for round-robin tie-break; default is fixed MEM priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    localparam logic [2:0] LAT = 3'(RAM_RD_LAT);

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  last_idx;
    logic [2:0]  mem_last;
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        rdy_q;
    logic [7:0]  din_hold;
    logic [7:0]  byte_in;
    logic [1:0]  rd_idx;
    logic [1:0]  wr_idx;
    logic        grant_mem;
    logic        grant_if;
    logic        idle_ok;

    // No new grant in the cycle a done pulse is being presented.
    assign idle_ok = !if_done_o && !mem_done_o;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_mem <= 1'b0;
        end else if (rdy && state == IDLE && idle_ok) begin
            if (grant_mem) begin
                last_mem <= 1'b1;
            end else if (grant_if) begin
                last_mem <= 1'b0;
            end
        end
    end

    assign grant_mem = mem_req_i && !(if_req_i && !if_cancel_i && last_mem);
`else
    assign grant_mem = mem_req_i;
`endif

    assign grant_if = !grant_mem && if_req_i && !if_cancel_i;

    always_comb begin
        case (mem_len_i)
            2'd0:    mem_last = 3'd0;
            2'd1:    mem_last = 3'd1;
            default: mem_last = 3'd3;
        endcase
    end

    // The RAM keeps reading the frozen address while rdy is low, so the byte that
    // was on ram_din when the freeze began is held and used on resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q    <= 1'b0;
            din_hold <= '0;
        end else begin
            rdy_q <= rdy;
            if (rdy_q) begin
                din_hold <= ram_din;
            end
        end
    end

    assign byte_in = rdy_q ? ram_din : din_hold;
    assign rd_idx  = 2'(cnt - LAT);
    assign wr_idx  = 2'(cnt + 3'd1);

    always_comb begin
        asm_next = asm_q;
        if (cnt >= LAT) begin
            asm_next[{rd_idx, 3'b000} +: 8] = byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_idx    <= '0;
            asm_q       <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            ram_a       <= '0;
            ram_dout    <= '0;
            if_done_o   <= 1'b0;
            if_data_o   <= '0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= '0;
        end else if (rdy) begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    wr_q <= 1'b0;
                    if (idle_ok) begin
                        cnt   <= '0;
                        asm_q <= '0;
                        if (grant_mem) begin
                            ram_a    <= mem_addr_i;
                            last_idx <= mem_last;
                            wdata_q  <= mem_wdata_i;
                            if (mem_we_i) begin
                                state    <= MEM_WR;
                                wr_q     <= 1'b1;
                                ram_dout <= mem_wdata_i[7:0];
                            end else begin
                                state <= MEM_RD;
                            end
                        end else if (grant_if) begin
                            ram_a    <= if_addr_i;
                            last_idx <= 3'd3;
                            state    <= IF_RD;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && if_cancel_i) begin
                        state <= IDLE;
                    end else begin
                        asm_q <= asm_next;
                        cnt   <= cnt + 3'd1;
                        if (cnt < last_idx) begin
                            ram_a <= ram_a + ADDR_W'(1);
                        end
                        if (cnt == last_idx + LAT) begin
                            state <= IDLE;
                            if (state == IF_RD) begin
                                if_done_o <= 1'b1;
                                if_data_o <= asm_next;
                            end else begin
                                mem_done_o  <= 1'b1;
                                mem_rdata_o <= asm_next;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt == last_idx) begin
                        wr_q       <= 1'b0;
                        mem_done_o <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        ram_a    <= ram_a + ADDR_W'(1);
                        ram_dout <= wdata_q[{wr_idx, 3'b000} +: 8];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_wr = wr_q && rdy;
    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected RAM addresses, writes and done pulses
// are queued with their cycle numbers at stimulus time and checked as the DUT produces them.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_cancel_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        busy_o;

    mem_port_arbiter #(.ADDR_W(32), .RAM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_cancel_i(if_cancel_i),
        .if_done_o(if_done_o), .if_data_o(if_data_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_len_i(mem_len_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM with one-cycle registered read; fixed contents reloaded while rst is high.
    logic [7:0] ram_mem [0:65535];
    always @(posedge clk) begin
        if (rst) begin
            ram_mem[16'h0100] <= 8'h13; ram_mem[16'h0101] <= 8'h05;
            ram_mem[16'h0102] <= 8'h10; ram_mem[16'h0103] <= 8'h00;
            ram_mem[16'h0030] <= 8'h80; ram_mem[16'h0031] <= 8'h7F;
            ram_mem[16'h0040] <= 8'h11; ram_mem[16'h0041] <= 8'h22;
            ram_mem[16'h0042] <= 8'h33; ram_mem[16'h0043] <= 8'h44;
            ram_mem[16'hFFFE] <= 8'hA1; ram_mem[16'hFFFF] <= 8'hB2;
            ram_mem[16'h0000] <= 8'hC3; ram_mem[16'h0001] <= 8'hD4;
        end else if (ram_wr) begin
            ram_mem[ram_a[15:0]] <= ram_dout;
        end
        ram_din <= ram_mem[ram_a[15:0]];
    end

    typedef struct { int unsigned cyc; logic [31:0] addr; } ra_t;
    typedef struct { int unsigned cyc; logic [31:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int unsigned cyc; logic is_mem; logic chk_data; logic [31:0] data; } dn_t;
    ra_t ra_q[$];
    wr_t wr_q[$];
    dn_t dn_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void exp_ra(input int unsigned c, input logic [31:0] a);
        ra_q.push_back('{cyc: c, addr: a});
    endfunction

    function automatic void exp_wr(input int unsigned c, input logic [31:0] a, input logic [7:0] d);
        wr_q.push_back('{cyc: c, addr: a, data: d});
    endfunction

    function automatic void exp_dn(input int unsigned c, input logic m, input logic chk, input logic [31:0] d);
        dn_q.push_back('{cyc: c, is_mem: m, chk_data: chk, data: d});
    endfunction

    task automatic sb_done(input logic is_mem, input logic [31:0] data);
        dn_t e;
        if (dn_q.size() == 0) begin
            check_eq(is_mem ? "mem_done_spurious" : "if_done_spurious", 32'd1, 32'd0);
        end else begin
            e = dn_q.pop_front();
            check_eq("done_kind", {31'd0, is_mem}, {31'd0, e.is_mem});
            check_eq("done_cycle", cyc, e.cyc);
            if (e.chk_data) check_eq(is_mem ? "mem_rdata" : "if_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        while (ra_q.size() != 0 && ra_q[0].cyc <= cyc) begin
            if (ra_q[0].cyc == cyc) check_eq("ram_a", ram_a, ra_q[0].addr);
            else check_eq("ram_a_missed", cyc, ra_q[0].cyc);
            void'(ra_q.pop_front());
        end
        if (ram_wr) begin
            if (wr_q.size() == 0) begin
                check_eq("ram_wr_spurious", 32'd1, 32'd0);
            end else begin
                check_eq("wr_cycle", cyc, wr_q[0].cyc);
                check_eq("wr_addr", ram_a, wr_q[0].addr);
                check_eq("wr_data", {24'd0, ram_dout}, {24'd0, wr_q[0].data});
                void'(wr_q.pop_front());
            end
        end
        if (if_done_o)  sb_done(1'b0, if_data_o);
        if (mem_done_o) sb_done(1'b1, mem_rdata_o);
    end

    task automatic do_if(input logic [31:0] addr, input string tag);
        bit seen = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = addr;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = if_done_o;
        end
        if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        if_req_i = 1'b0;
    endtask

    task automatic wait_mem_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = mem_done_o;
        end
        if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        mem_req_i = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_len_i   = len;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        wait_mem_done(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        rst = 1'b1; rdy = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0; if_cancel_i = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_len_i = '0; mem_wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_if_done", {31'd0, if_done_o}, 32'd0);
        check_eq("rst_mem_done", {31'd0, mem_done_o}, 32'd0);
        check_eq("rst_ram_a", ram_a, 32'd0);
        check_eq("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check_eq("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_if_data", if_data_o, 32'd0);
        check_eq("rst_mem_rdata", mem_rdata_o, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Tie on the first request after reset, then MEM re-requests right after its done.
        @(posedge clk); #1 c = cyc;
        exp_ra(c + 1, 32'h30);
        exp_dn(c + 3, 1'b1, 1'b1, 32'h0000_0080);
`ifdef MEM_PORT_ARB_RR_EN
        for (int unsigned k = 0; k < 4; k++) exp_ra(c + 5 + k, 32'h100 + k);
        exp_dn(c + 10, 1'b0, 1'b1, 32'h0010_0513);
        exp_ra(c + 12, 32'h31);
        exp_dn(c + 14, 1'b1, 1'b1, 32'h0000_007F);
`else
        exp_ra(c + 5, 32'h31);
        exp_dn(c + 7, 1'b1, 1'b1, 32'h0000_007F);
        for (int unsigned k = 0; k < 4; k++) exp_ra(c + 9 + k, 32'h100 + k);
        exp_dn(c + 14, 1'b0, 1'b1, 32'h0010_0513);
`endif
        fork
            do_if(32'h100, "tie_if");
            begin
                do_mem(1'b0, 2'd0, 32'h30, 32'h0, "tie_mem0");
                @(posedge clk); #1;
                do_mem(1'b0, 2'd0, 32'h31, 32'h0, "tie_mem1");
            end
        join

        // Plain fetch.
        @(posedge clk); #1 c = cyc;
        for (int unsigned k = 0; k < 4; k++) exp_ra(c + 1 + k, 32'h100 + k);
        exp_dn(c + 6, 1'b0, 1'b1, 32'h0010_0513);
        do_if(32'h100, "fetch");
        check_eq("fetch_busy_done", {31'd0, busy_o}, 32'd0);

        // Half-word store then read back.
        @(posedge clk); #1 c = cyc;
        exp_wr(c + 1, 32'h2000, 8'hDD);
        exp_wr(c + 2, 32'h2001, 8'hCC);
        exp_dn(c + 3, 1'b1, 1'b0, 32'h0);
        do_mem(1'b1, 2'd1, 32'h2000, 32'hAABB_CCDD, "st_half");
        @(posedge clk); #1 c = cyc;
        exp_ra(c + 1, 32'h2000);
        exp_ra(c + 2, 32'h2001);
        exp_dn(c + 4, 1'b1, 1'b1, 32'h0000_CCDD);
        do_mem(1'b0, 2'd1, 32'h2000, 32'h0, "ld_half");

        // Fetch cancelled at T+3 with a MEM request waiting.
        @(posedge clk); #1 c = cyc;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        exp_ra(c + 1, 32'h100); exp_ra(c + 2, 32'h101);
        exp_ra(c + 3, 32'h102); exp_ra(c + 4, 32'h102);
        for (int unsigned k = 0; k < 4; k++) exp_ra(c + 5 + k, 32'h40 + k);
        exp_dn(c + 10, 1'b1, 1'b1, 32'h4433_2211);
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'd2; mem_addr_i = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1 if_cancel_i = 1'b1;
        @(negedge clk) check_eq("cancel_busy_pre", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1 if_cancel_i = 1'b0; if_req_i = 1'b0;
        @(negedge clk) check_eq("cancel_busy_post", {31'd0, busy_o}, 32'd0);
        wait_mem_done("cancel_mem");

        // Word load with rdy low for three cycles.
        @(posedge clk); #1 c = cyc;
        exp_ra(c + 1, 32'h40);
        for (int unsigned k = 2; k <= 5; k++) exp_ra(c + k, 32'h41);
        exp_ra(c + 6, 32'h42); exp_ra(c + 7, 32'h43);
        exp_dn(c + 9, 1'b1, 1'b1, 32'h4433_2211);
        fork
            do_mem(1'b0, 2'd2, 32'h40, 32'h0, "rdy_mem");
            begin
                @(posedge clk); @(posedge clk); #1 rdy = 1'b0;
                repeat (3) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join

        // Word load wrapping past the top of the address space.
        @(posedge clk); #1 c = cyc;
        exp_ra(c + 1, 32'hFFFF_FFFE); exp_ra(c + 2, 32'hFFFF_FFFF);
        exp_ra(c + 3, 32'h0000_0000); exp_ra(c + 4, 32'h0000_0001);
        exp_dn(c + 6, 1'b1, 1'b1, 32'hD4C3_B2A1);
        do_mem(1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, "wrap_mem");

        // Reset in the middle of a word store.
        @(posedge clk); #1 c = cyc;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'd2;
        mem_addr_i = 32'h2100; mem_wdata_i = 32'h0102_0304;
        exp_wr(c + 1, 32'h2100, 8'h04);
        exp_wr(c + 2, 32'h2101, 8'h03);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 mem_req_i = 1'b0;
        @(negedge clk);
        check_eq("rstmid_ram_wr", {31'd0, ram_wr}, 32'd0);
        check_eq("rstmid_ram_a", ram_a, 32'd0);
        check_eq("rstmid_ram_dout", {24'd0, ram_dout}, 32'd0);
        check_eq("rstmid_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rstmid_mem_done", {31'd0, mem_done_o}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(negedge clk);

        check_eq("ra_q_left", ra_q.size(), 32'd0);
        check_eq("wr_q_left", wr_q.size(), 32'd0);
        check_eq("dn_q_left", dn_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
